// File: rtl/rc4_stream_xor.sv
// rtl/rc4_stream_xor.sv - XORs RC4 keystream with a plaintext stream behind a keystream FIFO
module rc4_stream_xor #(
  parameter int NUMS_OF_BYTES = 16,
  parameter int KS_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] msg_length,
  input  logic       ks_valid,
  input  logic [7:0] ks_data,
  output logic       ks_ready,
  input  logic       pt_valid,
  input  logic [7:0] pt_data,
  output logic       pt_ready,
  output logic       ct_valid,
  output logic [7:0] ct_data,
  input  logic       ct_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_count
);

  localparam int AW = $clog2(KS_DEPTH);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(KS_DEPTH);
  localparam logic [7:0]  MAX_LEN   = 8'(NUMS_OF_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [7:0]    ks_mem [KS_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fifo_count;
  logic [7:0]    len;
  logic [7:0]    consumed;

  logic       run;
  logic       out_free;
  logic       ks_push;
  logic       pt_fire;
  logic       ct_fire;
  logic [8:0] in_flight;

  // Readies depend only on registered state, so a same-cycle pop never frees a push slot.
  assign run       = (state == S_RUN);
  assign in_flight = {1'b0, consumed} + 9'(fifo_count);
  assign out_free  = !ct_valid || ct_ready;
  assign ks_ready  = run && (fifo_count != FIFO_FULL) && (in_flight < {1'b0, len});
  assign pt_ready  = run && (fifo_count != '0) && (consumed < len) && out_free;
  assign ks_push   = ks_valid && ks_ready;
  assign pt_fire   = pt_valid && pt_ready;
  assign ct_fire   = ct_valid && ct_ready;
  assign busy      = run;

  always_ff @(posedge clk) begin
    if (ks_push) begin
      ks_mem[wr_ptr] <= ks_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      len        <= '0;
      consumed   <= '0;
      ct_valid   <= 1'b0;
      ct_data    <= '0;
      done       <= 1'b0;
      byte_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            byte_count <= '0;
            if (msg_length != 8'd0) begin
              state      <= S_RUN;
              len        <= (msg_length > MAX_LEN) ? MAX_LEN : msg_length;
              consumed   <= '0;
              rd_ptr     <= '0;
              wr_ptr     <= '0;
              fifo_count <= '0;
              ct_valid   <= 1'b0;
              done       <= 1'b0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ks_push) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          case ({ks_push, pt_fire})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
          endcase
          if (pt_fire) begin
            rd_ptr   <= rd_ptr + 1'b1;
            consumed <= consumed + 8'd1;
            ct_data  <= pt_data ^ ks_mem[rd_ptr];
            ct_valid <= 1'b1;
          end else if (ct_fire) begin
            ct_valid <= 1'b0;
          end
          if (ct_fire) begin
            byte_count <= byte_count + 8'd1;
            if (byte_count + 8'd1 == len) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_stream_xor.sv
// tb/tb_rc4_stream_xor.sv - scoreboard bench for rc4_stream_xor
module tb_rc4_stream_xor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] msg_length = '0;
  logic       ks_valid = 1'b0;
  logic [7:0] ks_data = '0;
  logic       ks_ready;
  logic       pt_valid = 1'b0;
  logic [7:0] pt_data = '0;
  logic       pt_ready;
  logic       ct_valid;
  logic [7:0] ct_data;
  logic       ct_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] byte_count;

  rc4_stream_xor #(.NUMS_OF_BYTES(16), .KS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_length(msg_length),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
    .busy(busy), .done(done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  logic [7:0] ks_arr[$];
  logic [7:0] pt_arr[$];
  int cur_len = 0;
  int mon_count = 0;
  bit pend_done = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;

  logic [7:0] ks_vec[9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
  logic [7:0] pt_vec[9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct_vec[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 0;
        pend_done = 0;
      end else begin
        if (pend_done) begin
          chk("done_after_last", done, 1);
          chk("busy_after_last", busy, 0);
          pend_done = 0;
        end
        if (prev_stall) begin
          chk("hold_valid", ct_valid, 1);
          chk("hold_data", ct_data, prev_data);
        end
        if (ct_valid && ct_ready) begin
          chk("byte_count_run", byte_count, mon_count);
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("ct_data", ct_data, exp_q.pop_front());
          end
          out_q.push_back(ct_data);
          mon_count++;
          if (mon_count == cur_len) begin
            chk("done_before_last", done, 0);
            pend_done = 1;
          end
        end
        prev_stall = ct_valid && !ct_ready;
        prev_data  = ct_data;
      end
    end
  end

  task automatic load_vec();
    ks_arr.delete();
    pt_arr.delete();
    for (int i = 0; i < 9; i++) begin
      ks_arr.push_back(ks_vec[i]);
      pt_arr.push_back(pt_vec[i]);
    end
  endtask

  task automatic check_vec();
    chk("vec_len", out_q.size(), 9);
    if (out_q.size() == 9) begin
      for (int i = 0; i < 9; i++) chk("vec_byte", out_q[i], ct_vec[i]);
    end
  endtask

  task automatic run_msg(input int len, input int ks_p, input int pt_p, input int ct_p,
                         input int pt_hold, input int pulse_at, input int abort_at);
    int ks_idx = 0;
    int pt_idx = 0;
    bit finished = 0;
    @(negedge clk);
    start = 1'b1;
    msg_length = 8'(len);
    ks_valid = 1'b0;
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    cur_len = len;
    mon_count = 0;
    out_q.delete();
    exp_q.delete();
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_at);
      msg_length = (cyc == pulse_at) ? 8'd5 : 8'(len);
      if (cyc == 0) begin
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_count", byte_count, 0);
      end
      if (pt_hold > 0 && cyc == pt_hold) begin
        chk("ks_pushed_limit", ks_idx, len);
        chk("ks_ready_limit", ks_ready, 0);
      end
      ks_valid = (ks_idx < ks_arr.size()) && ($urandom_range(0, 99) < ks_p);
      ks_data  = (ks_idx < ks_arr.size()) ? ks_arr[ks_idx] : 8'h00;
      pt_valid = (pt_idx < len) && (cyc >= pt_hold) && ($urandom_range(0, 99) < pt_p);
      pt_data  = (pt_idx < len) ? pt_arr[pt_idx] : 8'h00;
      ct_ready = ($urandom_range(0, 99) < ct_p);
      #1;
      if (done) begin
        finished = 1;
      end else if (abort_at >= 0 && byte_count == 8'(abort_at)) begin
        rst_n = 1'b0;
        #1;
        chk("abort_ct_valid", ct_valid, 0);
        chk("abort_ct_data", ct_data, 0);
        chk("abort_ks_ready", ks_ready, 0);
        chk("abort_pt_ready", pt_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_count", byte_count, 0);
        exp_q.delete();
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end else begin
        if (ks_valid && ks_ready) ks_idx++;
        if (pt_valid && pt_ready) begin
          exp_q.push_back(pt_arr[pt_idx] ^ ks_arr[pt_idx]);
          pt_idx++;
        end
      end
    end
    chk("msg_finished", finished, 1);
    ks_valid = 1'b0;
    pt_valid = 1'b0;
    #2;
    chk("end_count", byte_count, len);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_ct_valid", ct_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ks_ready", ks_ready, 0);
    chk("rst_pt_ready", pt_ready, 0);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_ct_data", ct_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", byte_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    load_vec();
    run_msg(9, 100, 100, 100, 0, -1, -1);
    check_vec();
    run_msg(9, 100, 100, 50, 0, -1, -1);
    check_vec();

    ks_arr.delete();
    pt_arr.delete();
    for (int i = 0; i < 20; i++) ks_arr.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) pt_arr.push_back(8'($urandom));
    run_msg(3, 100, 100, 100, 10, -1, -1);

    @(negedge clk);
    start = 1'b1;
    msg_length = 8'd0;
    ks_valid = 1'b1;
    pt_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_count", byte_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("zero_ks_ready", ks_ready, 0);
      chk("zero_pt_ready", pt_ready, 0);
      chk("zero_busy_hold", busy, 0);
    end
    ks_valid = 1'b0;
    pt_valid = 1'b0;

    load_vec();
    run_msg(9, 100, 100, 100, 0, -1, 4);
    run_msg(9, 100, 100, 100, 0, -1, -1);
    check_vec();

    run_msg(9, 70, 70, 70, 0, 3, -1);
    check_vec();

    for (int t = 0; t < 5; t++) begin
      int len = $urandom_range(1, 16);
      ks_arr.delete();
      pt_arr.delete();
      for (int i = 0; i < len + 4; i++) ks_arr.push_back(8'($urandom));
      for (int i = 0; i < len; i++) pt_arr.push_back(8'($urandom));
      run_msg(len, $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100), 0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_stream_xor.md
Name: rc4_stream_xor

Overview:
Downstream stage of rc4_new_design.
- Consumes the RC4 keystream bytes (ckey) one byte at a time and XORs them with an incoming plaintext byte stream.
- Emits ciphertext (or recovered plaintext) bytes on a registered valid/ready output.
- Buffers keystream in a small FIFO so the RC4 core can run ahead.
- Counts bytes against a programmed message length and flags done when the last output byte has been accepted.

Parameters:
NUMS_OF_BYTES, 16, maximum message length in bytes; msg_length must not exceed it.
KS_DEPTH, 4, keystream FIFO depth in bytes; power of two, minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new message; sampled only in IDLE or DONE
msg_length  input  8  number of bytes to process; sampled on accepted start
ks_valid  input  1  keystream byte available from RC4 core
ks_data  input  8  keystream byte
ks_ready  output  1  block accepts keystream byte this cycle
pt_valid  input  1  plaintext byte available
pt_data  input  8  plaintext byte
pt_ready  output  1  block accepts plaintext byte this cycle
ct_valid  output  1  output byte valid (registered)
ct_data  output  8  output byte = pt_data XOR ks_data (registered)
ct_ready  input  1  downstream accepts output byte
busy  output  1  high in RUN
done  output  1  level, high in DONE until next accepted start
byte_count  output  8  number of output bytes accepted by downstream in the current message

Behaviour:
- Reset: asynchronous and active-low on rst_n; one clock, clk.
  - State goes to IDLE; FIFO is emptied.
  - ks_ready=0, pt_ready=0, ct_valid=0, ct_data=0, busy=0, done=0, byte_count=0.
- Reset mid-operation aborts immediately: FIFO contents and the output register are discarded.
- States: IDLE, RUN, DONE.
  - IDLE/DONE, start=1, msg_length!=0: go to RUN. Latch msg_length; clear FIFO, byte_count, internal consumed counter and done.
  - IDLE/DONE, start=1, msg_length=0: go to (or stay in) DONE with done=1 and byte_count=0.
  - start in RUN is ignored.
  - RUN to DONE: on the cycle the output handshake (ct_valid and ct_ready) accepts byte number msg_length. done=1 from the next cycle.
- Keystream FIFO:
  - Push when ks_valid and ks_ready.
  - ks_ready = RUN, FIFO not full, and (consumed + fifo_count) < msg_length. The block never pulls keystream beyond the message length.
  - ks_ready is computed from registered state only, so a pop in the same cycle does not free a slot for a push.
  - Simultaneous push and pop (when not full) keep the count unchanged and preserve order.
- Plaintext / XOR:
  - out_free = (ct_valid=0) or ct_ready.
  - pt_ready = RUN, FIFO not empty, consumed < msg_length, and out_free.
  - On a pt handshake: pop FIFO head, ct_data <= pt_data XOR head, ct_valid <= 1, consumed += 1.
  - Latency: 1 cycle from pt handshake to ct_valid.
  - Full throughput is one byte per cycle when ct_ready stays high.
- Output register:
  - Holds ct_data and ct_valid stable while ct_valid=1 and ct_ready=0.
  - On a ct handshake with no new pt handshake, ct_valid <= 0.
  - byte_count increments on each ct handshake; it holds its final value in DONE.
- Counters are 8-bit. msg_length <= NUMS_OF_BYTES <= 255, so there is no wrap-around.
- No keystream byte is dropped or reordered; byte k of the output is pt[k] XOR ks[k].

Test Plan:
1. Key "Key" keystream EB 9F 77 81 B7 34 CA 72 A7, msg_length=9, plaintext 50 6C 61 69 6E 74 65 78 74 ("Plaintext"), ct_ready=1.
   - Required output: BB F3 16 E8 D9 40 AF 0A D3.
   - done rises one cycle after the 9th ct handshake; byte_count=9.
2. Same data with ct_ready toggled 1/0 randomly.
   - ct_data holds stable while stalled.
   - Output sequence is identical to scenario 1; no duplicates or drops.
3. ks_valid held high with 20 keystream bytes offered, msg_length=3, pt_valid=0 initially.
   - ks_ready drops after 3 pushes (FIFO count=3), not 4.
   - Then 3 plaintext bytes produce exactly 3 outputs; done=1.
4. start with msg_length=0.
   - done=1 on the next cycle, busy never set, ks_ready/pt_ready stay 0, byte_count=0.
5. Assert rst_n=0 after 4 of 9 bytes in scenario 1.
   - All outputs return to 0 asynchronously.
   - A subsequent start with msg_length=9 reproduces the full scenario 1 output from byte 0.
6. start pulsed during RUN.
   - Ignored; message completes normally.
   - A start in DONE clears done and byte_count the next cycle and reruns.
